// File: rtl/kmeans_pkg.sv
// Shared types, default widths and flat-bus slice helpers for the K-means mean divider.
package kmeans_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DIV,
    STORE,
    DONE
  } state_t;

  localparam int ACC_W_DEF        = 20;
  localparam int CNT_W_DEF        = 12;
  localparam int NUM_CLUSTERS_DEF = 16;
  localparam int NUM_CHANNELS_DEF = 3;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit offset of accumulator/mean slice (c*nch+ch) on a flat bus of w-bit fields.
  function automatic int acc_base(input int c, input int ch, input int nch, input int w);
    return (c * nch + ch) * w;
  endfunction

  function automatic int cnt_base(input int c, input int w);
    return c * w;
  endfunction

endpackage

// File: rtl/cluster_mean_divider_div.sv
// Serial restoring divider: one quotient bit per enabled cycle, MSB first.
module serial_restoring_divider #(
  parameter int DVD_W = 20,
  parameter int DVS_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             load,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic             valid,
  output logic             last
);

  localparam int N_W = $clog2(DVD_W + 1);

  logic [N_W-1:0]   iter_q;
  logic [DVS_W:0]   rem_q;
  logic [DVS_W:0]   rem_sh;
  logic [DVD_W-1:0] quo_q;
  logic [DVS_W-1:0] dvs_q;
  logic             fit;

  // The dividend register doubles as the quotient register: bits shift out at the top
  // into the remainder and quotient bits shift in at the bottom.
  always_comb begin
    rem_sh = (rem_q << 1) | (DVS_W+1)'(quo_q[DVD_W-1]);
    fit    = rem_sh >= {1'b0, dvs_q};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iter_q <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else if (ce) begin
      if (load) begin
        iter_q <= N_W'(DVD_W);
        rem_q  <= '0;
        quo_q  <= dividend;
        dvs_q  <= divisor;
      end else if (iter_q != '0) begin
        rem_q  <= fit ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
        quo_q  <= {quo_q[DVD_W-2:0], fit};
        iter_q <= iter_q - N_W'(1);
      end
    end
  end

  assign quotient = quo_q;
  assign valid    = (iter_q == '0);
  assign last     = (iter_q == N_W'(1));

endmodule

// File: rtl/cluster_mean_divider.sv
// Per-cluster, per-channel mean = accum / count using one time-shared serial divider.
// Build option MEAN_ROUND_EN: round-half-up with saturation instead of floor.
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | inspect cluster c: skip disabled/empty, else load divider for channel 0
// DIV   | serial division in progress
// STORE | write quotient to mean[c][ch], load next channel or advance cluster
// DONE  | one-cycle done pulse, back to IDLE
module cluster_mean_divider
  import kmeans_pkg::*;
#(
  parameter int NUM_CLUSTERS = NUM_CLUSTERS_DEF,
  parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
  parameter int ACC_W        = ACC_W_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     ce,
  input  logic                                     start,
  input  logic [NUM_CLUSTERS-1:0]                  en,
  input  logic [NUM_CLUSTERS*NUM_CHANNELS*ACC_W-1:0] accum_flat,
  input  logic [NUM_CLUSTERS*CNT_W-1:0]            count_flat,
  output logic                                     busy,
  output logic                                     done,
  output logic [NUM_CLUSTERS-1:0]                  empty,
  output logic [NUM_CLUSTERS*NUM_CHANNELS*ACC_W-1:0] mean_flat
);

  localparam int C_W  = idx_w(NUM_CLUSTERS);
  localparam int CH_W = idx_w(NUM_CHANNELS);
`ifdef MEAN_ROUND_EN
  localparam int DIV_W = ACC_W + 1;
`else
  localparam int DIV_W = ACC_W;
`endif

  state_t state_q, state_d;

  logic [NUM_CLUSTERS-1:0]                   en_q;
  logic [NUM_CLUSTERS*NUM_CHANNELS*ACC_W-1:0] acc_q;
  logic [NUM_CLUSTERS*CNT_W-1:0]             cnt_q;
  logic [NUM_CLUSTERS*NUM_CHANNELS*ACC_W-1:0] mean_q;
  logic [NUM_CLUSTERS-1:0]                   empty_q;
  logic                                      busy_q, done_q;
  logic [C_W-1:0]                            c_q;
  logic [CH_W-1:0]                           ch_q, ld_ch;

  logic             cur_en, cnt_zero, last_c, last_ch;
  logic [CNT_W-1:0] cur_cnt;
  logic [ACC_W-1:0] cur_acc;
  logic             div_load, div_valid, div_last;
  logic [DIV_W-1:0] div_dividend, div_quotient;
  logic [ACC_W-1:0] div_mean;

  always_comb begin
    cur_en   = en_q[c_q];
    cur_cnt  = cnt_q[cnt_base(int'(c_q), CNT_W) +: CNT_W];
    cnt_zero = (cur_cnt == '0);
    last_c   = (c_q == C_W'(NUM_CLUSTERS - 1));
    last_ch  = (ch_q == CH_W'(NUM_CHANNELS - 1));
    state_d  = state_q;
    div_load = 1'b0;
    ld_ch    = '0;
    case (state_q)
      IDLE: if (start) state_d = SCAN;
      SCAN: begin
        if (cur_en && !cnt_zero) begin
          div_load = 1'b1;
          state_d  = DIV;
        end else begin
          state_d = last_c ? DONE : SCAN;
        end
      end
      DIV: if (div_last) state_d = STORE;
      STORE: begin
        if (!last_ch) begin
          div_load = 1'b1;
          ld_ch    = ch_q + CH_W'(1);
          state_d  = DIV;
        end else begin
          state_d = last_c ? DONE : SCAN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cur_acc = acc_q[acc_base(int'(c_q), int'(ld_ch), NUM_CHANNELS, ACC_W) +: ACC_W];
  end

  // Rounding adds count/2 at one extra bit; the quotient can then exceed ACC_W bits.
  always_comb begin
`ifdef MEAN_ROUND_EN
    div_dividend = {1'b0, cur_acc} + DIV_W'(cur_cnt >> 1);
    div_mean     = div_quotient[ACC_W] ? '1 : div_quotient[ACC_W-1:0];
`else
    div_dividend = cur_acc;
    div_mean     = div_quotient;
`endif
  end

  serial_restoring_divider #(
    .DVD_W(DIV_W),
    .DVS_W(CNT_W)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .load     (div_load),
    .dividend (div_dividend),
    .divisor  (cur_cnt),
    .quotient (div_quotient),
    .valid    (div_valid),
    .last     (div_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      en_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      mean_q  <= '0;
      empty_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_q     <= '0;
      ch_q    <= '0;
    end else if (ce) begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            en_q    <= en;
            acc_q   <= accum_flat;
            cnt_q   <= count_flat;
            empty_q <= '0;
            c_q     <= '0;
            ch_q    <= '0;
            busy_q  <= 1'b1;
          end
        end
        SCAN: begin
          if (cur_en && cnt_zero) empty_q[c_q] <= 1'b1;
          if (state_d == DONE) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else if (state_d == SCAN) begin
            c_q <= c_q + C_W'(1);
          end
        end
        STORE: begin
          if (div_valid)
            mean_q[acc_base(int'(c_q), int'(ch_q), NUM_CHANNELS, ACC_W) +: ACC_W] <= div_mean;
          if (!last_ch) begin
            ch_q <= ld_ch;
          end else begin
            ch_q <= '0;
            if (last_c) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              c_q <= c_q + C_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign empty     = empty_q;
  assign mean_flat = mean_q;

endmodule

// File: tb/tb_cluster_mean_divider.sv
// Randomized self-checking bench for cluster_mean_divider against an arithmetic mean model.
module tb_cluster_mean_divider;
  import kmeans_pkg::*;

  localparam int K  = 16;
  localparam int CH = 3;
  localparam int AW = 20;
  localparam int CW = 12;
`ifdef MEAN_ROUND_EN
  localparam int DLEN = AW + 1;
`else
  localparam int DLEN = AW;
`endif
  localparam longint MAXV = (64'd1 << AW) - 1;

  logic                 clk = 1'b0;
  logic                 reset, ce, start;
  logic [K-1:0]         en;
  logic [K*CH*AW-1:0]   accum_flat;
  logic [K*CW-1:0]      count_flat;
  logic                 busy, done;
  logic [K-1:0]         empty;
  logic [K*CH*AW-1:0]   mean_flat;

  always #5 clk = ~clk;

  cluster_mean_divider #(
    .NUM_CLUSTERS(K),
    .NUM_CHANNELS(CH),
    .ACC_W(AW),
    .CNT_W(CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .start      (start),
    .en         (en),
    .accum_flat (accum_flat),
    .count_flat (count_flat),
    .busy       (busy),
    .done       (done),
    .empty      (empty),
    .mean_flat  (mean_flat)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: inputs as seen at the accepting edge, means kept across runs.
  bit     m_en[K];
  longint m_acc[K][CH];
  longint m_cnt[K];
  longint m_mean[K][CH];
  bit     m_empty[K];
  int     m_edges;

  function automatic longint ref_mean(input longint a, input longint n);
`ifdef MEAN_ROUND_EN
    longint q;
    q = (a + n / 2) / n;
    return (q > MAXV) ? MAXV : q;
`else
    return a / n;
`endif
  endfunction

  task automatic clear_inputs();
    for (int c = 0; c < K; c++) begin
      m_en[c]  = 1'b0;
      m_cnt[c] = 0;
      for (int ch = 0; ch < CH; ch++) m_acc[c][ch] = 0;
    end
  endtask

  task automatic rand_inputs(input bit all_en);
    for (int c = 0; c < K; c++) begin
      m_en[c] = all_en ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       m_cnt[c] = all_en ? 1 : 0;
        1:       m_cnt[c] = 1;
        2:       m_cnt[c] = (1 << CW) - 1;
        default: m_cnt[c] = $urandom_range(2, (1 << CW) - 1);
      endcase
      for (int ch = 0; ch < CH; ch++)
        m_acc[c][ch] = ($urandom_range(0, 7) == 0) ? MAXV : longint'($urandom_range(0, int'(MAXV)));
    end
  endtask

  task automatic drive_inputs();
    for (int c = 0; c < K; c++) begin
      en[c] = m_en[c];
      count_flat[c*CW +: CW] = CW'(m_cnt[c]);
      for (int ch = 0; ch < CH; ch++) accum_flat[(c*CH+ch)*AW +: AW] = AW'(m_acc[c][ch]);
    end
  endtask

  task automatic scramble_inputs();
    for (int c = 0; c < K; c++) begin
      en[c] = 1'($urandom);
      count_flat[c*CW +: CW] = CW'($urandom);
      for (int ch = 0; ch < CH; ch++) accum_flat[(c*CH+ch)*AW +: AW] = AW'($urandom);
    end
  endtask

  task automatic model_run();
    int ne;
    ne = 0;
    for (int c = 0; c < K; c++) begin
      m_empty[c] = 1'b0;
      if (m_en[c]) begin
        if (m_cnt[c] == 0) m_empty[c] = 1'b1;
        else begin
          ne++;
          for (int ch = 0; ch < CH; ch++) m_mean[c][ch] = ref_mean(m_acc[c][ch], m_cnt[c]);
        end
      end
    end
    m_edges = K + ne * CH * (DLEN + 1);
  endtask

  task automatic check_outputs(input string tag);
    for (int c = 0; c < K; c++) begin
      chk($sformatf("%s empty[%0d]", tag, c), 64'(empty[c]), 64'(m_empty[c]));
      for (int ch = 0; ch < CH; ch++)
        chk($sformatf("%s mean[%0d][%0d]", tag, c, ch),
            64'(mean_flat[(c*CH+ch)*AW +: AW]), m_mean[c][ch]);
    end
  endtask

  // Caller sits 1 time unit after a posedge with the DUT idle.
  task automatic run_job(input string tag, input bit ce_rand, input bit poke);
    int edges;
    bit seen;
    drive_inputs();
    model_run();
    ce = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " busy_accept"}, 64'(busy), 64'd1);
    if (poke) scramble_inputs();
    edges = 0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 20000 && !seen; cyc++) begin
      ce = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (poke && (cyc == 100 || cyc == 700)) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      if (ce) edges++;
      if (done) seen = 1'b1;
      else chk({tag, " busy_run"}, 64'(busy), 64'd1);
    end
    start = 1'b0;
    chk({tag, " done_seen"}, 64'(seen), 64'd1);
    chk({tag, " done_edge"}, 64'(edges), 64'(m_edges));
    chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
    ce = 1'b1;
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, 64'(done), 64'd0);
    check_outputs(tag);
  endtask

  initial begin
    reset = 1'b0;
    ce = 1'b0;
    start = 1'b0;
    en = '0;
    accum_flat = '0;
    count_flat = '0;
    clear_inputs();
    for (int c = 0; c < K; c++) begin
      m_empty[c] = 1'b0;
      for (int ch = 0; ch < CH; ch++) m_mean[c][ch] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst empty", 64'(empty), 64'd0);
    chk("rst mean_zero", 64'(mean_flat == '0), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;

    // Cluster 0 only: 300/301/302 over 3
    clear_inputs();
    m_en[0] = 1'b1;
    m_cnt[0] = 3;
    m_acc[0][0] = 300; m_acc[0][1] = 301; m_acc[0][2] = 302;
    run_job("c0", 1'b0, 1'b0);

    // Prime cluster 5 with 0x55, then run it empty: mean held
    clear_inputs();
    m_en[5] = 1'b1;
    m_cnt[5] = 1;
    for (int ch = 0; ch < CH; ch++) m_acc[5][ch] = 'h55;
    run_job("prime5", 1'b0, 1'b0);
    m_cnt[5] = 0;
    run_job("empty5", 1'b0, 1'b0);

    // Rounding corner and full-scale dividend
    clear_inputs();
    m_en[1] = 1'b1; m_cnt[1] = 2;
    m_en[2] = 1'b1; m_cnt[2] = 1;
    for (int ch = 0; ch < CH; ch++) begin
      m_acc[1][ch] = 7;
      m_acc[2][ch] = MAXV;
    end
    run_job("corner", 1'b0, 1'b0);

    // All enabled, inputs scrambled after accept, extra start pulses while busy
    rand_inputs(1'b1);
    run_job("all_rand", 1'b0, 1'b1);
    run_job("all_rand_ce", 1'b1, 1'b0);

    rand_inputs(1'b0);
    run_job("mix_ce", 1'b1, 1'b0);
    rand_inputs(1'b0);
    run_job("mix", 1'b0, 1'b0);

    // Asynchronous reset in the middle of a run
    rand_inputs(1'b1);
    drive_inputs();
    ce = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (300) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort empty", 64'(empty), 64'd0);
    chk("abort mean_zero", 64'(mean_flat == '0), 64'd1);
    reset = 1'b1;
    for (int c = 0; c < K; c++)
      for (int ch = 0; ch < CH; ch++) m_mean[c][ch] = 0;
    @(posedge clk); #1;
    chk("abort idle busy", 64'(busy), 64'd0);
    rand_inputs(1'b0);
    run_job("after_abort", 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cluster_mean_divider.md
Name: cluster_mean_divider

Overview:
- Parametrised successor to the per-colour K-means mean divider: computes mean = accum / count for every enabled cluster and every colour channel.
- Uses one time-shared serial restoring divider instead of one combinational divider per cluster per channel.
- Sits between the cluster accumulators and the centroid registers; fires once per K-means iteration on a start pulse and reports done.

Parameters:
- NUM_CLUSTERS, 16, number of clusters K (1..64)
- NUM_CHANNELS, 3, colour channels per pixel (R,G,B order = channel 0,1,2)
- ACC_W, 20, accumulator width; also quotient and mean width
- CNT_W, 12, pixel-count width (CNT_W <= ACC_W)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- ce  in  1  clock enable; when low all state, counters and outputs hold
- start  in  1  one-cycle request to compute all means
- en  in  NUM_CLUSTERS  per-cluster enable
- accum_flat  in  NUM_CLUSTERS*NUM_CHANNELS*ACC_W  accumulators; slice index (c*NUM_CHANNELS+ch)
- count_flat  in  NUM_CLUSTERS*CNT_W  per-cluster pixel counts
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse when all means are written (replaces final_ready)
- empty  out  NUM_CLUSTERS  cluster was enabled with count==0 in the last run
- mean_flat  out  NUM_CLUSTERS*NUM_CHANNELS*ACC_W  registered means, same slicing as accum_flat

Behaviour:
- Reset: busy=0, done=0, empty=0, mean_flat=0, FSM=IDLE, indices 0. Reset asserted mid-run aborts immediately.
- All sequential updates are qualified by ce; latencies below count ce-high cycles.
- start is accepted only in IDLE. On acceptance: snapshot en, accum_flat and count_flat; clear empty; c=0, ch=0; go to SCAN; busy=1. start while busy is ignored. Inputs may change freely after the accepting edge.
- SCAN (1 cycle per cluster):
  - en[c]=0: skip the cluster.
  - en[c]=1 and count=0: set empty[c]; skip the cluster; mean held.
  - Otherwise: load the divider with accum[c][0] and count[c]; go to DIV.
  - A skip of the last cluster goes to DONE; any other skip increments c.
- DIV: ACC_W iterations, 1 quotient bit per cycle, MSB first.
  - Remainder width CNT_W+1.
  - Result = floor(accum/count), exact for all inputs including accum = 2^ACC_W-1, count=1.
- STORE (1 cycle): write the quotient to mean[c][ch].
  - ch < NUM_CHANNELS-1: ch++, load the next channel, go to DIV.
  - Otherwise: ch=0; go to DONE if c is last, else c++ and go to SCAN.
- DONE: done=1 for exactly one cycle; busy=0; return to IDLE. A new start is accepted in the IDLE cycle that follows.
- Latency: done is registered high at the E-th ce edge after the accepting edge, where E = NUM_CLUSTERS + Ne*NUM_CHANNELS*(ACC_W+1) and Ne = number of enabled, non-empty clusters. Default, all enabled: 16 + 48*21 = 1024.
- Disabled and empty clusters keep their previous means (the centroid is retained).
- mean_flat is registered and changes only in STORE.

Optional Feature:
- Macro: MEAN_ROUND_EN.
- Defined: dividend = accum + (count>>1), computed at ACC_W+1 bits; quotient saturates at 2^ACC_W-1; round-half-up. DIV becomes ACC_W+1 cycles per channel; the latency formula uses ACC_W+2.
- Undefined: truncating floor division, as above.

Decomposition:
- Package kmeans_pkg: state enum (IDLE, SCAN, DIV, STORE, DONE); default widths ACC_W_DEF=20 and CNT_W_DEF=12; NUM_CLUSTERS_DEF=16; NUM_CHANNELS_DEF=3; slice-index helper functions.
- Sub-module serial_restoring_divider:
  - Parameters: dividend width, divisor width.
  - Ports: load, dividend, divisor, quotient, valid.
  - Owns the iteration counter.
- Top level owns the FSM, snapshot registers, indices and the output bank.

Test Plan:
- Cluster 0 only enabled, accum R/G/B = 300/301/302, count=3 -> means 100/100/100; done at edge 16+3*21=79; all other means remain 0.
- Cluster 5 enabled with count=0, prior mean 0x55 -> mean held at 0x55, empty[5]=1, done at edge 16.
- accum=7, count=2 -> mean 3 without MEAN_ROUND_EN, 4 with it. accum=0xFFFFF, count=1 -> 0xFFFFF in both builds.
- All 16 enabled with random accum/count -> every mean equals the floor model; done at edge 1024; busy high throughout; second start pulse mid-run ignored.
- ce toggling 50% during a run -> results identical; done delayed exactly by the number of ce-low cycles.
- reset pulled low at cycle 300 -> busy, done, empty and means all 0 asynchronously; fresh start afterwards completes normally.
